// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps through stored LED patterns, updating the serializer word only on frame boundaries
module led_pattern_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int DWELL_W = 24
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [15:0]        i_wr_data,
  input  logic               i_run,
  input  logic [AW-1:0]      i_last_slot,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_frame_done,
  output logic [15:0]        o_data,
  output logic [AW-1:0]      o_slot,
  output logic               o_wrap,
  output logic               o_active
);
  typedef enum logic [1:0] {IDLE, DWELL, WAIT_FRAME, STOP_WAIT} state_t;
  state_t             r_state, w_state_nxt;
  logic [15:0]        r_ram [DEPTH];
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt, w_dwell_ld;
  logic [AW-1:0]      r_slot, w_slot_nxt, r_next, w_next_nxt;
  logic [15:0]        r_data, w_data_nxt, w_rd_cur, w_rd_next;
  logic               r_wrap, w_wrap_nxt, r_first, w_first_nxt, r_fd_q, w_fd;
  assign w_fd       = i_frame_done & ~r_fd_q;
  assign w_dwell_ld = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
  assign w_rd_cur   = (i_wr_en && i_wr_addr == r_slot) ? i_wr_data : r_ram[r_slot];
  assign w_rd_next  = (i_wr_en && i_wr_addr == r_next) ? i_wr_data : r_ram[r_next];
  assign o_data     = r_data;
  assign o_slot     = r_slot;
  assign o_wrap     = r_wrap;
  assign o_active   = r_state != IDLE;
  // pattern storage; contents are left unreset
  always_ff @(posedge i_clk) if (i_wr_en) r_ram[i_wr_addr] <= i_wr_data;
  // state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_next  <= '0;
      r_data  <= '0;
      r_wrap  <= 1'b0;
      r_first <= 1'b0;
      r_fd_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_slot  <= w_slot_nxt;
      r_next  <= w_next_nxt;
      r_data  <= w_data_nxt;
      r_wrap  <= w_wrap_nxt;
      r_first <= w_first_nxt;
      r_fd_q  <= i_frame_done;
    end
  end
  // next-state: dwell countdown, frame-aligned slot changes, stop and blank
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_slot_nxt  = r_slot;
    w_next_nxt  = r_next;
    w_data_nxt  = r_data;
    w_wrap_nxt  = 1'b0;
    w_first_nxt = r_first;
    case (r_state)
      IDLE: if (i_run) begin
        w_state_nxt = WAIT_FRAME;
        w_cnt_nxt   = w_dwell_ld;
        w_slot_nxt  = '0;
        w_next_nxt  = '0;
        w_first_nxt = 1'b1;
      end
      DWELL: if (!i_run) w_state_nxt = STOP_WAIT;
      else begin
        if (w_fd) w_data_nxt = w_rd_cur;
        if (r_cnt <= DWELL_W'(1)) begin
          w_state_nxt = WAIT_FRAME;
          w_next_nxt  = (r_slot >= i_last_slot) ? '0 : r_slot + 1'b1;
        end else w_cnt_nxt = r_cnt - 1'b1;
      end
      WAIT_FRAME: if (!i_run) w_state_nxt = STOP_WAIT;
      else if (w_fd) begin
        w_state_nxt = DWELL;
        w_slot_nxt  = r_next;
        w_data_nxt  = w_rd_next;
        w_cnt_nxt   = w_dwell_ld;
        w_wrap_nxt  = (r_next == '0) && !r_first;
        w_first_nxt = 1'b0;
      end
      STOP_WAIT: if (w_fd) begin
        w_state_nxt = IDLE;
        w_data_nxt  = '0;
        w_slot_nxt  = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: vector table, directed corner cases and random run against a timing model
module tb_led_pattern_sequencer;
  logic        clk = 1'b0, rst_n, run, fd, wr_en;
  logic [2:0]  wr_addr, last, o_slot;
  logic [15:0] wr_data, o_data;
  logic [23:0] dwell;
  logic        o_wrap, o_active, found;
  int n_chk = 0, n_fail = 0;

  led_pattern_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_run(run), .i_last_slot(last), .i_dwell(dwell), .i_frame_done(fd),
    .o_data(o_data), .o_slot(o_slot), .o_wrap(o_wrap), .o_active(o_active)
  );

  always #5 clk = ~clk;

  // model: idle/running/stopping, slot timing kept as an absolute "ready" cycle
  logic [15:0] m_mem [8];
  logic [15:0] m_data;
  logic [2:0]  m_slot, m_next;
  logic        m_wrap, m_first, m_fdq, m_act;
  int          m_mode, m_cyc = 0, m_ready;

  typedef struct { logic run, fd; logic [15:0] data; logic [2:0] slot; logic wrap, act; } vec_t;
  vec_t tbl [17];

  function automatic logic [15:0] rdm(input logic [2:0] a);
    return (wr_en && wr_addr == a) ? wr_data : m_mem[a];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_data = '0; m_slot = '0; m_next = '0; m_wrap = 1'b0; m_first = 1'b0; m_fdq = 1'b0;
    m_act = 1'b0; m_cyc++;
  endtask

  task automatic model_step();
    logic fe;
    int d;
    fe = fd && !m_fdq;
    d = (dwell == 0) ? 1 : int'(dwell);
    m_wrap = 1'b0;
    if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_first = 1'b1; m_next = '0; m_ready = m_cyc + 1; end
    end else if (m_mode == 1) begin
      if (!run) m_mode = 2;
      else begin
        if (m_cyc == m_ready - 1 && !m_first) m_next = (m_slot >= last) ? 3'd0 : m_slot + 3'd1;
        if (fe && m_cyc >= m_ready) begin
          m_wrap = (m_next == 3'd0) && !m_first;
          m_first = 1'b0;
          m_slot = m_next;
          m_data = rdm(m_next);
          m_ready = m_cyc + 1 + d;
        end else if (fe) m_data = rdm(m_slot);
      end
    end else if (fe) begin
      m_mode = 0; m_data = '0; m_slot = '0;
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
    m_fdq = fd;
    m_act = m_mode != 0;
    m_cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk); #1;
    chk("cycle", {11'd0, o_data, o_slot, o_wrap, o_active}, {11'd0, m_data, m_slot, m_wrap, m_act});
  endtask

  task automatic idle(input int n);
    fd = 1'b0;
    repeat (n) tick();
  endtask

  task automatic frame();
    fd = 1'b1; tick();
    fd = 1'b0; tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 16'h0001, 3'd0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 16'h0001, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 16'h0002, 3'd1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 16'h0002, 3'd1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 16'h0002, 3'd1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 16'h0004, 3'd2, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 16'h0004, 3'd2, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 16'h0004, 3'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 16'h0001, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 16'h0001, 3'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 16'h0001, 3'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 16'h0001, 3'd0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 16'h0001, 3'd0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 16'h0000, 3'd0, 1'b0, 1'b0};

    rst_n = 1'b0; run = 1'b0; fd = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; last = '0; dwell = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = (i == 0) ? 16'hA5A5 : 16'(16'h0010 * i);
      tick();
    end
    wr_en = 1'b0;

    // asynchronous reset while a pattern is displayed
    last = 3'd0; dwell = 24'd3; run = 1'b1;
    tick();
    frame();
    chk("a5a5_shown", o_data, 16'hA5A5);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", {o_data, o_slot, o_wrap, o_active}, 21'd0);
    run = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) frame();
    chk("idle_blank", {o_data, o_active}, 17'd0);

    // vector table: basic sequence, held frame_done, stop and restart
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(1 << i);
      tick();
    end
    wr_en = 1'b0; last = 3'd2; dwell = 24'd0;
    tick();
    for (int i = 0; i < 17; i++) begin
      run = tbl[i].run; fd = tbl[i].fd;
      tick();
      chk($sformatf("tbl%0d", i), {o_data, o_slot, o_wrap, o_active},
          {tbl[i].data, tbl[i].slot, tbl[i].wrap, tbl[i].act});
    end

    // live edit of the displayed slot, bypassed on the frame edge
    fd = 1'b0; dwell = 24'd10; run = 1'b1;
    tick();
    frame();
    idle(12);
    frame();
    chk("edit_slot1", {o_data, o_slot}, {16'h0002, 3'd1});
    fd = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hFFFF;
    tick();
    chk("edit_bypass", o_data, 16'hFFFF);
    wr_en = 1'b0; fd = 1'b0;
    tick();

    // frame edge coincident with dwell expiry only refreshes
    dwell = 24'd3;
    idle(12);
    frame();
    idle(1);
    fd = 1'b1; tick();
    chk("coinc_hold", o_slot, 3'd2);
    fd = 1'b0; tick();
    fd = 1'b1; tick();
    chk("coinc_adv", {o_slot, o_wrap}, {3'd0, 1'b1});
    fd = 1'b0; tick();

    // stop while showing 0004
    dwell = 24'd0;
    idle(4);
    frame();
    idle(2);
    frame();
    chk("stop_pre", o_data, 16'h0004);
    run = 1'b0;
    idle(3);
    chk("stop_hold", {o_data, o_active}, {16'h0004, 1'b1});
    fd = 1'b1; tick();
    chk("stop_done", {o_data, o_slot, o_active}, 20'd0);
    fd = 1'b0;

    // wrap point lowered below the current slot
    last = 3'd7; run = 1'b1;
    tick();
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      fd = 1'b1; tick();
      if (o_slot == 3'd5) begin found = 1'b1; break; end
      fd = 1'b0; tick();
      idle(2);
    end
    chk("wp_reach5", {found, o_slot}, {1'b1, 3'd5});
    last = 3'd3;
    idle(3);
    fd = 1'b1; tick();
    chk("wp_wrap", {o_slot, o_wrap}, {3'd0, 1'b1});
    fd = 1'b0; tick();
    chk("wp_wrap_pulse", o_wrap, 1'b0);

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) run = ~run;
      fd = ($urandom_range(0, 3) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wr_addr = 3'($urandom);
      wr_data = 16'($urandom);
      if ($urandom_range(0, 49) == 0) last = 3'($urandom);
      if ($urandom_range(0, 19) == 0) dwell = 24'($urandom_range(0, 5));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
